// File: rtl/cic_decimator_iq_pkg.sv
// Channel indexing and width helpers shared by the I/Q CIC decimator.
package cic_decimator_iq_pkg;

    localparam int NUM_CH = 2;
    localparam int CH_I   = 0;
    localparam int CH_Q   = 1;

    function automatic int acc_width(input int in_w, input int growth);
        return in_w + growth;
    endfunction

    // Counter width for 0..r-1; r is at least 2 so $clog2 never returns 0.
    function automatic int cnt_width(input int r);
        return (r <= 2) ? 1 : $clog2(r);
    endfunction

endpackage

// File: rtl/cic_comb.sv
// One CIC comb stage: on each enabled (decimated) clock, dout = din - previous din.
import cic_decimator_iq_pkg::*;

module cic_comb #(
    parameter int WIDTH = 49
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] delay;

    // Differentiate against the previous decimated sample; wraps modulo 2^WIDTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            delay <= '0;
            dout  <= '0;
        end else if (en) begin
            delay <= din;
            dout  <= din - delay;
        end
    end

endmodule

// File: rtl/cic_defs.vh
// Shared CIC defaults and parameter range-check helpers.
// Optional feature macro: CIC_ROUND_EN (left undefined by default), which turns on
// round-half-up with positive saturation and adds one output pipeline register.
`ifndef CIC_DEFS_VH
`define CIC_DEFS_VH

`define CIC_IN_WIDTH   22
`define CIC_OUT_WIDTH  24
`define CIC_STAGES     5
`define CIC_DECIMATION 40
`define CIC_GROWTH     27

// CIC_ROUND_EN is intentionally not defined here; define it on the command line to enable rounding.

`define CIC_IN_RANGE(v, lo, hi) (((v) >= (lo)) && ((v) <= (hi)))
`define CIC_STAGES_OK(n)        `CIC_IN_RANGE(n, 1, 8)
`define CIC_DECIMATION_OK(r)    `CIC_IN_RANGE(r, 2, 1024)

`endif

// File: rtl/cic_decimator_iq.sv
// Dual-channel (I/Q) CIC decimator: STAGES pipelined integrators, sample counter,
// comb chain of cic_comb instances, scaling to OUT_WIDTH and out_strobe generation.
// Define CIC_ROUND_EN for round-half-up + positive saturation (latency STAGES+2);
// otherwise plain truncation with latency STAGES+1.
`include "cic_defs.vh"

module cic_decimator_iq
    import cic_decimator_iq_pkg::*;
#(
    parameter int IN_WIDTH   = `CIC_IN_WIDTH,
    parameter int OUT_WIDTH  = `CIC_OUT_WIDTH,
    parameter int STAGES     = `CIC_STAGES,
    parameter int DECIMATION = `CIC_DECIMATION,
    parameter int GROWTH     = `CIC_GROWTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_strobe,
    input  logic signed [IN_WIDTH-1:0]  in_i,
    input  logic signed [IN_WIDTH-1:0]  in_q,
    output logic                        out_strobe,
    output logic signed [OUT_WIDTH-1:0] out_i,
    output logic signed [OUT_WIDTH-1:0] out_q
);

    localparam int ACC_WIDTH = acc_width(IN_WIDTH, GROWTH);
    localparam int DROP      = ACC_WIDTH - OUT_WIDTH;
    localparam int CNT_W     = cnt_width(DECIMATION);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATION - 1);
`ifdef CIC_ROUND_EN
    localparam int PIPE = STAGES + 2;
`else
    localparam int PIPE = STAGES + 1;
`endif

    logic [NUM_CH-1:0][IN_WIDTH-1:0]              din;
    logic [NUM_CH-1:0][STAGES-1:0][ACC_WIDTH-1:0] integ;
    logic [NUM_CH-1:0][ACC_WIDTH-1:0]             cap;
    logic [NUM_CH-1:0][STAGES:0][ACC_WIDTH-1:0]   comb;
    logic [NUM_CH-1:0][OUT_WIDTH-1:0]             dout;
    logic [CNT_W-1:0]                             cnt;
    // vld_pipe[0] marks the decimation event; bit k enables comb stage k.
    logic [PIPE:0]                                vld_pipe;

    assign din[CH_I] = in_i;
    assign din[CH_Q] = in_q;

    // Integrator cascade; stage k uses stage k-1's registered value, so the chain is pipelined.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            integ <= '0;
        end else if (in_strobe) begin
            for (int c = 0; c < NUM_CH; c++) begin
                integ[c][0] <= integ[c][0] + {{GROWTH{din[c][IN_WIDTH-1]}}, din[c]};
                for (int k = 1; k < STAGES; k++)
                    integ[c][k] <= integ[c][k] + integ[c][k-1];
            end
        end
    end

    // Count accepted strobes and launch a token down the valid pipe on the last one of each window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[PIPE-1:0], in_strobe && (cnt == CNT_LAST)};
            if (in_strobe)
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Sample the last integrator once per window as the comb chain input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap <= '0;
        end else if (vld_pipe[0]) begin
            for (int c = 0; c < NUM_CH; c++)
                cap[c] <= integ[c][STAGES-1];
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign comb[c][0] = cap[c];
        for (genvar g = 0; g < STAGES; g++) begin : g_comb
            cic_comb #(.WIDTH(ACC_WIDTH)) u_comb (
                .clock (clock),
                .reset (reset),
                .en    (vld_pipe[g+1]),
                .din   (comb[c][g]),
                .dout  (comb[c][g+1])
            );
        end
    end

`ifdef CIC_ROUND_EN
    localparam logic [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (DROP - 1);

    logic [NUM_CH-1:0][ACC_WIDTH:0] rnd;
    logic [NUM_CH-1:0][OUT_WIDTH:0] rnd_top;
    logic [NUM_CH-1:0]              unused_rnd_lsbs;

    // One guard bit above the sum keeps the +half from wrapping near positive full scale.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_rnd
        assign rnd[c]             = {comb[c][STAGES][ACC_WIDTH-1], comb[c][STAGES]} + HALF;
        assign rnd_top[c]         = rnd[c][ACC_WIDTH -: OUT_WIDTH+1];
        assign unused_rnd_lsbs[c] = ^rnd[c][DROP-1:0];
    end

    // Extra output register: rounded value, clamped on positive overflow (negative cannot overflow).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else if (vld_pipe[PIPE-1]) begin
            for (int c = 0; c < NUM_CH; c++)
                dout[c] <= (!rnd_top[c][OUT_WIDTH] && rnd_top[c][OUT_WIDTH-1])
                           ? {1'b0, {(OUT_WIDTH-1){1'b1}}}
                           : rnd_top[c][OUT_WIDTH-1:0];
        end
    end
`else
    logic [NUM_CH-1:0] unused_trunc_lsbs;

    // The last comb register doubles as the output register; only its top bits are presented.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_trunc
        assign dout[c]              = comb[c][STAGES][ACC_WIDTH-1 -: OUT_WIDTH];
        assign unused_trunc_lsbs[c] = ^comb[c][STAGES][DROP-1:0];
    end
`endif

    assign out_i      = dout[CH_I];
    assign out_q      = dout[CH_Q];
    assign out_strobe = vld_pipe[PIPE];

endmodule
